shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, pipelined multi-mode barrel shifter for the execute stage. It supports logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand. The shifter is built as log2(WIDTH) shift layers, each of distance 2^i, with a register after every layer. Operands are accepted with a valid/ready handshake and carry an opaque tag to the output, so the issue logic can track results.

## Interface
Parameters:
- WIDTH, 32, operand width; must be a power of two, ≥ 8.
- TAG_W, 4, width of the pass-through tag; must be ≥ 1.
- SHAMT_W, log2(WIDTH), derived localparam; not overridable.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift distance, 0..WIDTH-1.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Layer i (i = 0..SHAMT_W-1) shifts by 2^i when shamt bit i is 1; otherwise it passes the data through.
- Each layer register holds data, shamt, op, tag, a sign bit (the original operand MSB) and a valid bit.
- Fill rules per op:
  - SLL fills zeros at the LSB end.
  - SRL fills zeros at the MSB end.
  - SRA fills with the latched sign bit in every layer. The sign comes from the original operand, not from an intermediate layer's MSB.
  - ROR wraps the bits shifted out of the LSB end back into the MSB end.
- The result equals the single-step operation by in_shamt. A shamt of 0 returns in_data unchanged for all ops.
- Global-stall pipeline: advance = out_ready | ~out_valid, and in_ready = advance.
  - When advance is 1, every layer register loads from the layer before it.
  - Layer 0 loads in_valid & in_ready together with the operand fields.
  - When advance is 0, every layer register holds its contents.
- Bubbles are not collapsed. An empty stage still waits for a stall to release.
- Results leave in strict acceptance order.
- flush:
  - Clears every valid bit on the next edge and discards any operand offered in the same cycle.
  - Has priority over advance and stall.
  - in_ready is unaffected by flush.
  - Data registers may retain stale values.
- Reset values:
  - All valid bits, out_valid, out_data and out_tag are 0.
  - in_ready is 1 after reset, because out_valid = 0.

## Timing
- Latency: SHAMT_W cycles from the accepting edge to out_valid with no stall (5 for WIDTH=32).
- Throughput: one operation per cycle while out_ready = 1.
- out_data, out_tag and out_valid come straight from the last layer register, with no combinational path from the inputs.
- in_ready is combinational from out_ready and out_valid only.
- While out_valid & ~out_ready, out_data and out_tag hold stable until the handshake completes.
- Simultaneous out handshake and in acceptance in the same cycle is legal; both complete.
- rst_n assertion mid-operation clears all valid bits immediately (asynchronously). No partial result is ever presented.
- in_shamt is taken as unsigned; values are always in range by width.

## Structure
- Shared package shift_pkg holds:
  - the shift_op_e enum (SLL, SRL, SRA, ROR, 2 bits);
  - a stage payload struct (data, shamt, op, tag, sign, valid), parametrised via the enclosing module.
- One sub-module, shift_layer: parameters WIDTH, DIST. It contains one conditional shift of DIST bits for all four ops, plus the register with enable, flush and async reset.
- shift_pipe instantiates SHAMT_W shift_layer instances in a generate loop with DIST = 2^i.

## Test plan
- WIDTH=32, SRA 0x80000000 by 31 → 0xFFFFFFFF; SRL same operand → 0x00000001; SLL 0x00000001 by 31 → 0x80000000; out_valid exactly 5 cycles after accept.
- ROR 0x12345678 by 8 → 0x78123456; shamt 0 with each op on 0xA5A5A5A5 → 0xA5A5A5A5; SRA 0x7FFFFFF0 by 4 → 0x07FFFFFF.
- Back-to-back stream of 8 ops with tags 0..7; out_ready held low for 3 cycles mid-stream → in_ready low during the stall, no loss, tags emerge 0..7 in order, out_data stable while stalled.
- flush asserted with 3 ops in flight and in_valid=1 → no out_valid for any of them; the next op accepted after flush completes normally.
- rst_n pulsed low mid-stream → out_valid, out_data and out_tag go to 0 asynchronously; in_ready=1 after release.
- WIDTH=16, TAG_W=1 instance: SRA 0x8001 by 15 → 0xFFFF, latency 4; random compare against a reference model over 10k ops with random out_ready.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   shift_op_e : 2-bit operation encoding presented on in_op.
// The per-stage payload struct is declared inside shift_layer, because its field
// widths follow that module's WIDTH/TAG_W parameters and a package cannot be
// parametrised.
package shift_pkg;

  typedef enum logic [1:0] {
    Sll = 2'b00,  // logical left, zero fill at LSB
    Srl = 2'b01,  // logical right, zero fill at MSB
    Sra = 2'b10,  // arithmetic right, fill with original operand MSB
    Ror = 2'b11   // rotate right
  } shift_op_e;

endpackage

// File: rtl/shift_layer.sv
// One layer of the shifter: conditionally shifts by DIST (a power of two) when the
// matching shamt bit is set, then registers the full stage payload.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous clear of the valid bit (wins over en)
//   en                : load enable (global pipeline advance)
//   *_i               : payload from the previous layer (or the input port)
//   *_o               : registered payload for the next layer
module shift_layer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DIST  = 1,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               en,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  shift_op_e          op_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               sign_i,
  input  logic               valid_i,
  output logic [WIDTH-1:0]   data_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output shift_op_e          op_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic               sign_o,
  output logic               valid_o
);

  localparam int unsigned BIT = $clog2(DIST);

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    shift_op_e          op;
    logic [TAG_W-1:0]   tag;
    logic               sign;
    logic               valid;
  } stage_t;

  stage_t           stage_d, stage_q;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = data_i;
    unique case (op_i)
      Sll: shifted = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
      Srl: shifted = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
      // Sign comes from the original operand; the running MSB may already be shifted.
      Sra: shifted = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
      Ror: shifted = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
    endcase
  end

  always_comb begin
    stage_d.data  = shamt_i[BIT] ? shifted : data_i;
    stage_d.shamt = shamt_i;
    stage_d.op    = op_i;
    stage_d.tag   = tag_i;
    stage_d.sign  = sign_i;
    stage_d.valid = valid_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (flush) begin
      // Payload fields may go stale; only the valid bit matters.
      stage_q.valid <= 1'b0;
    end else if (en) begin
      stage_q <= stage_d;
    end
  end

  assign data_o  = stage_q.data;
  assign shamt_o = stage_q.shamt;
  assign op_o    = stage_q.op;
  assign tag_o   = stage_q.tag;
  assign sign_o  = stage_q.sign;
  assign valid_o = stage_q.valid;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined multi-mode barrel shifter (SLL/SRL/SRA/ROR) with a register after
// each of the log2(WIDTH) shift layers and a global-stall valid/ready handshake.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous kill of every in-flight operation
//   in_valid/in_ready     : operand handshake; in_ready = out_ready | ~out_valid
//   in_data/in_shamt/in_op/in_tag : operand, distance, operation, opaque tag
//   out_valid/out_ready   : result handshake
//   out_data/out_tag      : result and its tag, straight from the last register
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  // Index 0 is the input port; index i+1 is the register after layer i.
  logic [WIDTH-1:0]   st_data  [SHAMT_W+1];
  logic [SHAMT_W-1:0] st_shamt [SHAMT_W+1];
  shift_op_e          st_op    [SHAMT_W+1];
  logic [TAG_W-1:0]   st_tag   [SHAMT_W+1];
  logic               st_sign  [SHAMT_W+1];
  logic               st_valid [SHAMT_W+1];

  logic advance;

  // Whole pipe moves together; an empty last stage never blocks.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  assign st_data[0]  = in_data;
  assign st_shamt[0] = in_shamt;
  assign st_op[0]    = shift_op_e'(in_op);
  assign st_tag[0]   = in_tag;
  assign st_sign[0]  = in_data[WIDTH-1];
  assign st_valid[0] = in_valid & advance;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_layer
    shift_layer #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .DIST  (1 << i)
    ) u_layer (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .en      (advance),
      .data_i  (st_data[i]),
      .shamt_i (st_shamt[i]),
      .op_i    (st_op[i]),
      .tag_i   (st_tag[i]),
      .sign_i  (st_sign[i]),
      .valid_i (st_valid[i]),
      .data_o  (st_data[i+1]),
      .shamt_o (st_shamt[i+1]),
      .op_o    (st_op[i+1]),
      .tag_o   (st_tag[i+1]),
      .sign_o  (st_sign[i+1]),
      .valid_o (st_valid[i+1])
    );
  end

  assign out_valid = st_valid[SHAMT_W];
  assign out_data  = st_data[SHAMT_W];
  assign out_tag   = st_tag[SHAMT_W];

  // Control fields of the last register are carried along but not needed at the output.
  logic unused_last;
  assign unused_last = ^{st_shamt[SHAMT_W], st_op[SHAMT_W], st_sign[SHAMT_W]};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed + randomised bench for shift_pipe: a WIDTH=32/TAG_W=4 instance for the
// directed cases and a WIDTH=16/TAG_W=1 instance for a reference-model stream.
module tb_shift_pipe;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_data, a_out_data;
  logic [4:0]  a_shamt;
  logic [1:0]  a_op;
  logic [3:0]  a_tag, a_out_tag;

  // 16-bit instance
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_data, b_out_data;
  logic [3:0]  b_shamt;
  logic [1:0]  b_op;
  logic [0:0]  b_tag, b_out_tag;

  shift_pipe #(.WIDTH(32), .TAG_W(4)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_data),
    .in_shamt  (a_shamt),
    .in_op     (a_op),
    .in_tag    (a_tag),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_tag   (a_out_tag)
  );

  shift_pipe #(.WIDTH(16), .TAG_W(1)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_data),
    .in_shamt  (b_shamt),
    .in_op     (b_op),
    .in_tag    (b_tag),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_tag   (b_out_tag)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Independent reference for the 16-bit instance.
  function automatic logic [15:0] ref16(input logic [15:0] d, input logic [3:0] s,
                                        input logic [1:0] op);
    logic [15:0] r;
    case (op)
      SLL:     r = d << s;
      SRL:     r = d >> s;
      SRA:     r = 16'($signed(d) >>> s);
      default: r = (s == 4'd0) ? d : ((d >> s) | (d << (5'd16 - {1'b0, s})));
    endcase
    return r;
  endfunction

  // Single op into an empty 32-bit pipe; measures edges until out_valid.
  task automatic run_a(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                       input logic [3:0] tag, input logic [31:0] exp, input string name);
    int n;
    a_data = d; a_shamt = sh; a_op = op; a_tag = tag;
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
      a_in_valid = 1'b0;
    end while (!a_out_valid && n < 20);
    check({name, " latency"}, 32'(n), 32'd5);
    check({name, " data"}, a_out_data, exp);
    check({name, " tag"}, {28'b0, a_out_tag}, {28'b0, tag});
    cyc();
  endtask

  task automatic run_b(input logic [15:0] d, input logic [3:0] sh, input logic [1:0] op,
                       input logic [0:0] tag, input logic [15:0] exp, input string name);
    int n;
    b_data = d; b_shamt = sh; b_op = op; b_tag = tag;
    b_in_valid = 1'b1; b_out_ready = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
      b_in_valid = 1'b0;
    end while (!b_out_valid && n < 20);
    check({name, " latency"}, 32'(n), 32'd4);
    check({name, " data"}, {16'b0, b_out_data}, {16'b0, exp});
    check({name, " tag"}, {31'b0, b_out_tag}, {31'b0, tag});
    cyc();
  endtask

  int          sent, got, c, seen, issued, n;
  logic [31:0] held;
  logic [16:0] sb[$];
  logic [16:0] exp17;

  initial begin
    rst_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    a_data = '0; a_shamt = '0; a_op = SLL; a_tag = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_data = '0; b_shamt = '0; b_op = SLL; b_tag = '0;

    // Reset state (out_ready low so in_ready reflects only out_valid)
    repeat (2) cyc();
    check("reset out_valid", {31'b0, a_out_valid}, 32'd0);
    check("reset out_data", a_out_data, 32'd0);
    check("reset out_tag", {28'b0, a_out_tag}, 32'd0);
    check("reset in_ready", {31'b0, a_in_ready}, 32'd1);
    check("reset b in_ready", {31'b0, b_in_ready}, 32'd1);
    rst_n = 1'b1;
    cyc();

    // Boundary shifts and latency
    run_a(32'h8000_0000, 5'd31, SRA, 4'h1, 32'hFFFF_FFFF, "sra 31");
    run_a(32'h8000_0000, 5'd31, SRL, 4'h2, 32'h0000_0001, "srl 31");
    run_a(32'h0000_0001, 5'd31, SLL, 4'h3, 32'h8000_0000, "sll 31");
    run_a(32'h1234_5678, 5'd8,  ROR, 4'h4, 32'h7812_3456, "ror 8");
    run_a(32'hA5A5_A5A5, 5'd0,  SLL, 4'h5, 32'hA5A5_A5A5, "sll 0");
    run_a(32'hA5A5_A5A5, 5'd0,  SRL, 4'h6, 32'hA5A5_A5A5, "srl 0");
    run_a(32'hA5A5_A5A5, 5'd0,  SRA, 4'h7, 32'hA5A5_A5A5, "sra 0");
    run_a(32'hA5A5_A5A5, 5'd0,  ROR, 4'h8, 32'hA5A5_A5A5, "ror 0");
    run_a(32'h7FFF_FFF0, 5'd4,  SRA, 4'h9, 32'h07FF_FFFF, "sra pos 4");
    run_a(32'h8765_4321, 5'd5,  SRA, 4'hB, 32'hFC3B_2A19, "sra neg 5");
    run_a(32'h8765_4321, 5'd12, ROR, 4'hD, 32'h3218_7654, "ror 12");

    // Back-to-back stream with a 3-cycle output stall (cycles 6..8)
    sent = 0; got = 0; c = 0; held = '0;
    while (got < 8 && c < 60) begin
      a_out_ready = !(c >= 6 && c <= 8);
      a_in_valid  = (sent < 8);
      a_data = 32'h1; a_shamt = sent[4:0]; a_op = SLL; a_tag = sent[3:0];
      #1;
      if (c >= 6 && c <= 8) begin
        check("stall in_ready", {31'b0, a_in_ready}, 32'd0);
        check("stall out_valid", {31'b0, a_out_valid}, 32'd1);
        if (c == 6) held = a_out_data;
        else check("stall data hold", a_out_data, held);
      end
      if (a_out_valid && a_out_ready) begin
        check("stream tag", {28'b0, a_out_tag}, 32'(got));
        check("stream data", a_out_data, 32'd1 << got);
        got++;
      end
      if (a_in_valid && a_in_ready) sent++;
      cyc();
      c++;
    end
    check("stream count", 32'(got), 32'd8);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    cyc();

    // Flush with three ops in flight and an operand offered in the flush cycle
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1; a_data = 32'hDEAD_0000 + 32'(k); a_shamt = '0; a_op = SLL;
      a_tag = 4'(k + 1);
      cyc();
    end
    a_flush = 1'b1; a_tag = 4'h4;
    #1;
    check("flush in_ready", {31'b0, a_in_ready}, 32'd1);
    cyc();
    a_flush = 1'b0; a_in_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      if (a_out_valid) seen++;
      cyc();
    end
    check("flush no out_valid", 32'(seen), 32'd0);
    run_a(32'hF0F0_0000, 5'd16, SRL, 4'hC, 32'h0000_F0F0, "post flush srl");

    // Asynchronous reset mid-stream
    for (int k = 0; k < 7; k++) begin
      a_in_valid = 1'b1; a_data = 32'hFFFF_FFFF; a_shamt = '0; a_op = SRA; a_tag = 4'hA;
      cyc();
    end
    check("pre-reset out_valid", {31'b0, a_out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", {31'b0, a_out_valid}, 32'd0);
    check("async rst out_data", a_out_data, 32'd0);
    check("async rst out_tag", {28'b0, a_out_tag}, 32'd0);
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post rst in_ready", {31'b0, a_in_ready}, 32'd1);
    cyc();
    check("post rst no result", {31'b0, a_out_valid}, 32'd0);
    a_out_ready = 1'b1;

    // 16-bit instance
    run_b(16'h8001, 4'd15, SRA, 1'b1, 16'hFFFF, "w16 sra 15");
    run_b(16'h1234, 4'd4,  ROR, 1'b0, 16'h4123, "w16 ror 4");

    issued = 0; c = 0;
    while (issued < 10000 && c < 40000) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_data = 16'($urandom); b_shamt = 4'($urandom); b_op = 2'($urandom);
      b_tag = 1'($urandom);
      #1;
      if (b_out_valid && b_out_ready) begin
        if (sb.size() == 0) begin
          check("rand spurious out_valid", {31'b0, b_out_valid}, 32'd0);
        end else begin
          exp17 = sb.pop_front();
          check("rand result", {15'b0, b_out_tag, b_out_data}, {15'b0, exp17});
        end
      end
      if (b_in_valid && b_in_ready) begin
        sb.push_back({b_tag, ref16(b_data, b_shamt, b_op)});
        issued++;
      end
      cyc();
      c++;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      #1;
      if (b_out_valid) begin
        exp17 = sb.pop_front();
        check("rand drain result", {15'b0, b_out_tag, b_out_data}, {15'b0, exp17});
      end
      cyc();
      n++;
    end
    check("rand issued", 32'(issued), 32'd10000);
    check("rand drain empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
